// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the sequential chunked adder:
//   - default operand width and per-cycle chunk width
//   - FSM state encoding
//   - helper to size the chunk index register
// ----------------------------------------------------------------------------
package adder_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a counter that must hold 0..n-1. A single chunk still gets a
    // one-bit index so the register never collapses to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_ripple_adder.sv
// ----------------------------------------------------------------------------
// chunk_ripple_adder
// Purely combinational CHUNK-bit ripple-carry adder used once per clock by the
// sequential adder.
//
// Ports:
//   a, b   in  CHUNK  operand chunks (b already inverted for subtraction)
//   cin    in  1      carry into bit 0 of the chunk
//   s      out CHUNK  chunk sum
//   cout   out 1      carry out of the chunk MSB
//   c_msb  out 1      carry into the chunk MSB (for signed overflow detection)
// ----------------------------------------------------------------------------
module chunk_ripple_adder
    import adder_pkg::*;
#(
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// ----------------------------------------------------------------------------
// seq_chunk_adder
// Multi-cycle adder/subtractor that processes CHUNK bits per clock, least
// significant chunk first, taking N = WIDTH/CHUNK cycles per operation.
// WIDTH must be a multiple of CHUNK, and CHUNK at least 1.
//
// State table:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; results from last operation held
//   ST_RUN  | one chunk added per edge; start ignored
//   ST_DONE | one-cycle completion (done=1); start here chains a new op
//
// Ports:
//   clk        in   clock, rising-edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin an operation (accepted in IDLE or DONE)
//   sub        in   0 = A + B + carry_in, 1 = A - B
//   carry_in   in   carry into bit 0 (add mode only)
//   augend     in   operand A
//   addend     in   operand B
//   sum        out  result (held until the next operation completes)
//   carry_out  out  carry out of MSB; 1 = no borrow when subtracting
//   overflow   out  two's-complement overflow
//   zero       out  sum is all zeros
//   busy       out  high while in ST_RUN
//   done       out  one-cycle completion pulse
// ----------------------------------------------------------------------------
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] augend,
    input  logic [WIDTH-1:0] addend,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = idx_width(N);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    // Partial result is built here so the visible sum only changes at
    // completion.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_cmsb;

    logic accept;
    logic last_chunk;

    assign accept     = start && (state != ST_RUN);
    assign last_chunk = (state == ST_RUN) && (idx == LAST_IDX);

    assign chunk_a = a_reg[int'(idx) * CHUNK +: CHUNK];
    assign chunk_b = b_reg[int'(idx) * CHUNK +: CHUNK];

    chunk_ripple_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a     (chunk_a),
        .b     (chunk_b),
        .cin   (carry_reg),
        .s     (chunk_sum),
        .cout  (chunk_cout),
        .c_msb (chunk_cmsb)
    );

    always_comb begin
        acc_next = acc;
        acc_next[int'(idx) * CHUNK +: CHUNK] = chunk_sum;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (idx == LAST_IDX) state_next = ST_DONE;
            ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            acc       <= '0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1, so the inversion and the +1 seed are
            // applied once here and the datapath only ever adds.
            idx       <= '0;
            a_reg     <= augend;
            b_reg     <= sub ? ~addend : addend;
            carry_reg <= sub ? 1'b1 : carry_in;
        end else if (state == ST_RUN) begin
            acc       <= acc_next;
            carry_reg <= chunk_cout;
            idx       <= last_chunk ? '0 : idx + IDX_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (last_chunk) begin
                sum       <= acc_next;
                carry_out <= chunk_cout;
                overflow  <= chunk_cmsb ^ chunk_cout;
                zero      <= (acc_next == '0);
            end
            busy <= (state_next == ST_RUN);
            done <= (state_next == ST_DONE);
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
module tb_seq_chunk_adder;

    typedef struct {
        logic [31:0] sum;
        bit          cout;
        bit          ovf;
        bit          zero;
        int          acc_cyc;
        bit          chained;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i [3];
    logic        sub_i   [3];
    logic        cin_i   [3];
    logic [31:0] aug_i   [3];
    logic [31:0] add_i   [3];

    wire  [31:0] sum_o  [3];
    wire         cout_o [3];
    wire         ovf_o  [3];
    wire         zero_o [3];
    wire         busy_o [3];
    wire         done_o [3];

    wire  [15:0] s16;
    wire  [7:0]  s8;
    wire  [31:0] s32;

    int W  [3] = '{16, 8, 32};
    int NC [3] = '{4, 8, 4};

    exp_t sb [3][$];

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start_i[0]), .sub(sub_i[0]),
        .carry_in(cin_i[0]), .augend(aug_i[0][15:0]), .addend(add_i[0][15:0]),
        .sum(s16), .carry_out(cout_o[0]), .overflow(ovf_o[0]), .zero(zero_o[0]),
        .busy(busy_o[0]), .done(done_o[0])
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start_i[1]), .sub(sub_i[1]),
        .carry_in(cin_i[1]), .augend(aug_i[1][7:0]), .addend(add_i[1][7:0]),
        .sum(s8), .carry_out(cout_o[1]), .overflow(ovf_o[1]), .zero(zero_o[1]),
        .busy(busy_o[1]), .done(done_o[1])
    );

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start_i[2]), .sub(sub_i[2]),
        .carry_in(cin_i[2]), .augend(aug_i[2]), .addend(add_i[2]),
        .sum(s32), .carry_out(cout_o[2]), .overflow(ovf_o[2]), .zero(zero_o[2]),
        .busy(busy_o[2]), .done(done_o[2])
    );

    assign sum_o[0] = {16'h0, s16};
    assign sum_o[1] = {24'h0, s8};
    assign sum_o[2] = s32;

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s inst%0d t=%0t: got %0h required %0h", nm, k, $time, act, req);
        end
    endtask

    function automatic longint sgn(input longint unsigned v, input int w);
        longint unsigned half = 64'd1 << (w - 1);
        longint unsigned full = 64'd1 << w;
        return (v >= half) ? longint'(v) - longint'(full) : longint'(v);
    endfunction

    // Reference: plain integer arithmetic on W-bit values; signed overflow
    // from the true signed result leaving the representable range.
    function automatic exp_t ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                       input bit s, input bit c);
        exp_t r;
        longint unsigned m    = (64'd1 << w) - 64'd1;
        longint unsigned ua   = 64'(a) & m;
        longint unsigned ub   = 64'(b) & m;
        longint unsigned bop  = s ? (~ub) & m : ub;
        longint unsigned full = ua + bop + (s ? 64'd1 : 64'(c));
        longint sa   = sgn(ua, w);
        longint sb_v = sgn(ub, w);
        longint sr   = s ? sa - sb_v : sa + sb_v + longint'(c);
        longint smax = longint'((64'd1 << (w - 1)) - 64'd1);
        longint smin = -longint'(64'd1 << (w - 1));
        r.sum     = 32'(full & m);
        r.cout    = ((full >> w) & 64'd1) != 0;
        r.ovf     = (sr > smax) || (sr < smin);
        r.zero    = (full & m) == 0;
        r.acc_cyc = 0;
        r.chained = 1'b0;
        return r;
    endfunction

    // Monitor / scoreboard
    logic [31:0] last_sum  [3];
    bit          last_c    [3];
    bit          last_o    [3];
    bit          last_z    [3];
    int          busy_cnt  [3];
    int          last_done [3];
    exp_t        mon_e;

    initial begin
        for (int k = 0; k < 3; k++) begin
            last_sum[k] = '0; last_c[k] = 0; last_o[k] = 0; last_z[k] = 0;
            busy_cnt[k] = 0; last_done[k] = 0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                last_sum[k] = '0; last_c[k] = 0; last_o[k] = 0; last_z[k] = 0;
                busy_cnt[k] = 0;
            end else begin
                if (done_o[k]) begin
                    if (sb[k].size() == 0) begin
                        chk("unexpected_done", k, 64'(done_o[k]), 64'd0);
                    end else begin
                        mon_e = sb[k].pop_front();
                        chk("sum", k, 64'(sum_o[k]), 64'(mon_e.sum));
                        chk("carry_out", k, 64'(cout_o[k]), 64'(mon_e.cout));
                        chk("overflow", k, 64'(ovf_o[k]), 64'(mon_e.ovf));
                        chk("zero", k, 64'(zero_o[k]), 64'(mon_e.zero));
                        chk("latency", k, 64'(cyc - mon_e.acc_cyc), 64'(NC[k]));
                        chk("busy_cycles", k, 64'(busy_cnt[k]), 64'(NC[k]));
                        if (mon_e.chained)
                            chk("b2b_gap", k, 64'(cyc - last_done[k]), 64'(NC[k] + 1));
                        last_sum[k] = mon_e.sum;
                        last_c[k]   = mon_e.cout;
                        last_o[k]   = mon_e.ovf;
                        last_z[k]   = mon_e.zero;
                    end
                    busy_cnt[k]  = 0;
                    last_done[k] = cyc;
                end else begin
                    chk("hold", k, {sum_o[k], cout_o[k], ovf_o[k], zero_o[k]},
                        {last_sum[k], last_c[k], last_o[k], last_z[k]});
                end
                if (busy_o[k]) busy_cnt[k]++;
            end
        end
    end

    task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b,
                         input bit s, input bit c, input bit hold, input bit chained);
        exp_t e;
        bit   ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!busy_o[k]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("issue_timeout", k, 64'(busy_o[k]), 64'd0);
        end else begin
            aug_i[k] = a; add_i[k] = b; sub_i[k] = s; cin_i[k] = c; start_i[k] = 1'b1;
            @(posedge clk);
            #1;
            e = ref_model(W[k], a, b, s, c);
            e.acc_cyc = cyc;
            e.chained = chained;
            sb[k].push_back(e);
            if (!hold) start_i[k] = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0;
            2:       return 32'h8000_8080;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit held;
        bit h;
        bit drained;
        for (int k = 0; k < 3; k++) begin
            start_i[k] = 0; sub_i[k] = 0; cin_i[k] = 0; aug_i[k] = '0; add_i[k] = '0;
        end
        #2;
        for (int k = 0; k < 3; k++)
            chk("reset_outputs", k,
                {sum_o[k], cout_o[k], ovf_o[k], zero_o[k], busy_o[k], done_o[k]}, 64'd0);
        @(posedge clk); #3 rst_n = 1'b1;

        issue(0, 32'hFFFF, 32'h0001, 0, 0, 0, 0);
        issue(0, 32'h7FFF, 32'h0001, 0, 0, 0, 0);
        issue(0, 32'h0003, 32'h0005, 1, 1, 0, 0);
        issue(0, 32'h1234, 32'h1111, 0, 1, 0, 0);

        // start pulse with other operands during RUN must be ignored
        @(posedge clk); #1;
        aug_i[0] = 32'hAAAA; add_i[0] = 32'h5555; sub_i[0] = 1'b1; start_i[0] = 1'b1;
        @(posedge clk); #1;
        start_i[0] = 1'b0;

        // reset in RUN cycle 2 discards the operation
        issue(0, 32'h0F0F, 32'h0101, 0, 0, 0, 0);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("reset_midrun", 0,
            {sum_o[0], cout_o[0], ovf_o[0], zero_o[0], busy_o[0], done_o[0]}, 64'd0);
        for (int k = 0; k < 3; k++) sb[k].delete();
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        issue(0, 32'h00FF, 32'h0F01, 0, 1, 0, 0);

        // start held across DONE: chained operations
        issue(0, 32'h1111, 32'h2222, 0, 0, 1, 0);
        issue(0, 32'hFFFF, 32'hFFFF, 1, 1, 1, 1);
        issue(0, 32'h8000, 32'h0001, 1, 0, 0, 1);

        for (int k = 0; k < 3; k++) begin
            held = 1'b0;
            for (int i = 0; i < 30; i++) begin
                h = ($urandom_range(0, 2) == 0);
                issue(k, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), h, held);
                held = h;
                if (!h) repeat ($urandom_range(0, 3)) @(posedge clk);
            end
            start_i[k] = 1'b0;
        end

        drained = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        chk("drain", 0, 64'(drained), 64'd1);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog");
    end

endmodule
